// File: rtl/fp_alu_pkg.sv
// Shared constants and FSM state type for the FP add/sub datapath.
// Used by the alignment shifter and its sticky shift sub-block.
package fp_alu_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int SIG_W     = 24;
  localparam int GRS_W     = 3;
  localparam int ALIGN_W   = 27;
  localparam int ALIGN_SAT = 27;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } align_state_t;

endpackage

// File: rtl/fp_sticky_shifter.sv
// Combinational right shift of the aligned significand.
// Every bit shifted out is ORed into bit 0 (sticky).
module fp_sticky_shifter
  import fp_alu_pkg::*;
(
  input  logic [ALIGN_W-1:0] i_sig,
  input  logic [4:0]         i_k,
  output logic [ALIGN_W-1:0] o_sig
);

  logic [ALIGN_W-1:0] w_shr;
  logic [ALIGN_W-1:0] w_mask;
  logic               w_lost;

  always_comb begin
    w_shr  = i_sig >> i_k;
    w_mask = ~({ALIGN_W{1'b1}} << i_k);
    w_lost = |(i_sig & w_mask);
    o_sig  = {w_shr[ALIGN_W-1:1], w_shr[0] | w_lost};
  end

endmodule

// File: rtl/fp_align_shifter.sv
// Iterative FP operand alignment: order by magnitude, shift small sig.
// FP_ALIGN_SPECIAL_EN enables NaN/Inf bypass via the special flag.
module fp_align_shifter
  import fp_alu_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sign_large,
  output logic               sign_small,
  output logic [EXP_W-1:0]   exp_large,
  output logic [SIG_W-1:0]   sig_large,
  output logic [ALIGN_W-1:0] sig_small,
  output logic               swapped,
  output logic               special
);

  localparam logic [EXP_W-1:0] STEP = EXP_W'(SHIFT_STEP);
  localparam logic [EXP_W-1:0] SAT  = EXP_W'(ALIGN_SAT);

  align_state_t       r_state;
  logic               r_sign_large;
  logic               r_sign_small;
  logic [EXP_W-1:0]   r_exp_large;
  logic [SIG_W-1:0]   r_sig_large;
  logic [ALIGN_W-1:0] r_sig_small;
  logic               r_swapped;
  logic [EXP_W-1:0]   r_rem;

  logic [EXP_W-1:0]   w_exp_a;
  logic [EXP_W-1:0]   w_exp_b;
  logic [EXP_W-1:0]   w_eff_a;
  logic [EXP_W-1:0]   w_eff_b;
  logic [SIG_W-1:0]   w_sig_a;
  logic [SIG_W-1:0]   w_sig_b;
  logic               w_a_large;
  logic [EXP_W-1:0]   w_diff;
  logic [ALIGN_W-1:0] w_load;
  logic [ALIGN_W-1:0] w_sat;
  logic               w_spec;
  logic [EXP_W-1:0]   w_k;
  logic [EXP_W-1:0]   w_rem_nxt;
  logic [ALIGN_W-1:0] w_shifted;

  always_comb begin
    w_exp_a   = a[30:23];
    w_exp_b   = b[30:23];
    w_sig_a   = {|w_exp_a, a[22:0]};
    w_sig_b   = {|w_exp_b, b[22:0]};
    // denormals share the exponent of the smallest normal
    w_eff_a   = (w_exp_a == '0) ? 8'd1 : w_exp_a;
    w_eff_b   = (w_exp_b == '0) ? 8'd1 : w_exp_b;
    w_a_large = (w_exp_a > w_exp_b)
             || ((w_exp_a == w_exp_b)
             && (w_sig_a >= w_sig_b));
    w_diff    = w_a_large ? (w_eff_a - w_eff_b)
                          : (w_eff_b - w_eff_a);
    w_load    = {(w_a_large ? w_sig_b : w_sig_a), 3'b000};
    w_sat     = {{(ALIGN_W-1){1'b0}}, |w_load};
`ifdef FP_ALIGN_SPECIAL_EN
    w_spec    = (&w_exp_a) | (&w_exp_b);
`else
    w_spec    = 1'b0;
`endif
    w_k       = (r_rem < STEP) ? r_rem : STEP;
    w_rem_nxt = r_rem - w_k;
  end

  fp_sticky_shifter u_shift (
    .i_sig (r_sig_small),
    .i_k   (5'(w_k)),
    .o_sig (w_shifted)
  );

`ifdef FP_ALIGN_SPECIAL_EN
  logic r_special;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_special <= 1'b0;
    else if (r_state == IDLE && in_valid)
      r_special <= w_spec;
  end

  assign special = r_special;
`else
  assign special = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sign_large <= 1'b0;
      r_sign_small <= 1'b0;
      r_exp_large  <= '0;
      r_sig_large  <= '0;
      r_sig_small  <= '0;
      r_swapped    <= 1'b0;
      r_rem        <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign_large <= w_a_large ? a[31] : b[31];
            r_sign_small <= w_a_large ? b[31] : a[31];
            r_exp_large  <= w_a_large ? w_eff_a : w_eff_b;
            r_sig_large  <= w_a_large ? w_sig_a : w_sig_b;
            r_swapped    <= ~w_a_large;
            r_rem        <= '0;
            if (w_spec || w_diff == '0) begin
              r_sig_small <= w_load;
              r_state     <= DONE;
            end else if (w_diff >= SAT) begin
              r_sig_small <= w_sat;
              r_state     <= DONE;
            end else begin
              r_sig_small <= w_load;
              r_rem       <= w_diff;
              r_state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_sig_small <= w_shifted;
          r_rem       <= w_rem_nxt;
          if (w_rem_nxt == '0)
            r_state <= DONE;
        end
        DONE: begin
          if (out_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign sign_large = r_sign_large;
  assign sign_small = r_sign_small;
  assign exp_large  = r_exp_large;
  assign sig_large  = r_sig_large;
  assign sig_small  = r_sig_small;
  assign swapped    = r_swapped;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Directed self-checking bench for fp_align_shifter.
// Default build (special path disabled), SHIFT_STEP=4.
module tb_fp_align_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        sign_large;
  logic        sign_small;
  logic [7:0]  exp_large;
  logic [23:0] sig_large;
  logic [26:0] sig_small;
  logic        swapped;
  logic        special;

  int checks;
  int errors;

  fp_align_shifter #(.SHIFT_STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign_large (sign_large),
    .sign_small (sign_small),
    .exp_large  (exp_large),
    .sig_large  (sig_large),
    .sig_small  (sig_small),
    .swapped    (swapped),
    .special    (special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one operand pair, return after the accept edge (+1)
  task automatic issue(input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs out_valid=%b in_ready=%b want 0/1",
               out_valid, in_ready);
    end
    checks++;
    if (sig_small !== 27'd0 || sig_large !== 24'd0 ||
        exp_large !== 8'd0 || swapped !== 1'b0 ||
        special !== 1'b0 || sign_large !== 1'b0 ||
        sign_small !== 1'b0) begin
      errors++;
      $display("FAIL reset_data ss=%h sl=%h el=%0d sw=%b sp=%b want 0",
               sig_small, sig_large, exp_large, swapped, special);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    issue(32'h40400000, 32'h3F800000);
    wait_valid(lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL basic_lat got %0d want 2", lat);
    end
    checks++;
    if (swapped !== 1'b0 || exp_large !== 8'd128) begin
      errors++;
      $display("FAIL basic_order sw=%b el=%0d want 0/128",
               swapped, exp_large);
    end
    checks++;
    if (sig_large !== 24'hC00000) begin
      errors++;
      $display("FAIL basic_sigl got %h want c00000", sig_large);
    end
    checks++;
    if (sig_small !== 27'h2000000) begin
      errors++;
      $display("FAIL basic_sigs got %h want 2000000", sig_small);
    end
    consume();
  endtask

  task automatic test_swap_long();
    int lat;
    issue(32'hBF800000, 32'h4B800000);
    wait_valid(lat);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL swap_lat got %0d want 7", lat);
    end
    checks++;
    if (swapped !== 1'b1 || exp_large !== 8'd151) begin
      errors++;
      $display("FAIL swap_order sw=%b el=%0d want 1/151",
               swapped, exp_large);
    end
    checks++;
    if (sign_large !== 1'b0 || sign_small !== 1'b1) begin
      errors++;
      $display("FAIL swap_signs got %b%b want 01",
               sign_large, sign_small);
    end
    checks++;
    if (sig_small !== 27'h0000004) begin
      errors++;
      $display("FAIL swap_sigs got %h want 0000004", sig_small);
    end
    consume();
  endtask

  task automatic test_saturate();
    int lat;
    issue(32'h4F800000, 32'h3F800001);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL sat_lat got %0d want 1", lat);
    end
    checks++;
    if (sig_small !== 27'h0000001 || exp_large !== 8'd159) begin
      errors++;
      $display("FAIL sat_sigs got %h el=%0d want 0000001/159",
               sig_small, exp_large);
    end
    consume();
  endtask

  task automatic test_sticky();
    int lat;
    issue(32'h42000000, 32'h3F800001);
    wait_valid(lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL sticky_lat got %0d want 3", lat);
    end
    checks++;
    if (sig_small !== 27'h0200001) begin
      errors++;
      $display("FAIL sticky_sigs got %h want 0200001", sig_small);
    end
    consume();
  endtask

  task automatic test_equal();
    int lat;
    issue(32'h3F800000, 32'h3FC00000);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL eq_lat got %0d want 1", lat);
    end
    checks++;
    if (swapped !== 1'b1 || sig_large !== 24'hC00000 ||
        exp_large !== 8'd127) begin
      errors++;
      $display("FAIL eq_order sw=%b sl=%h el=%0d want 1/c00000/127",
               swapped, sig_large, exp_large);
    end
    checks++;
    if (sig_small !== 27'h4000000) begin
      errors++;
      $display("FAIL eq_sigs got %h want 4000000", sig_small);
    end
    consume();
  endtask

  task automatic test_denormal();
    int lat;
    // eff exp 1 vs 1, diff 0; larger sig wins
    issue(32'h00000003, 32'h00800000);
    wait_valid(lat);
    checks++;
    if (swapped !== 1'b1 || exp_large !== 8'd1 ||
        sig_small !== 27'h0000018 || lat !== 1) begin
      errors++;
      $display("FAIL denorm sw=%b el=%0d ss=%h lat=%0d want 1/1/18/1",
               swapped, exp_large, sig_small, lat);
    end
    consume();
  endtask

  task automatic test_backpressure_reset();
    int lat;
    logic ok;
    issue(32'h40400000, 32'h3F800000);
    wait_valid(lat);
    ok = 1'b1;
    in_valid = 1'b1;
    a = 32'h3F800000;
    b = 32'h4B800000;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          sig_small !== 27'h2000000 || exp_large !== 8'd128)
        ok = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_hold ov=%b ir=%b ss=%h want 1/0/2000000",
               out_valid, in_ready, sig_small);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release ov=%b ir=%b want 0/1",
               out_valid, in_ready);
    end
    issue(32'h3F800000, 32'h4B800000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        sig_small !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset ov=%b ir=%b ss=%h want 0/1/0",
               out_valid, in_ready, sig_small);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset ov=%b ir=%b want 0/1",
               out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h42000000, 32'h3F800001);
    wait_valid(lat);
    checks++;
    if (lat !== 3 || sig_small !== 27'h0200001 ||
        exp_large !== 8'd132) begin
      errors++;
      $display("FAIL after_reset lat=%0d ss=%h el=%0d want 3/0200001/132",
               lat, sig_small, exp_large);
    end
    consume();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    test_reset();
    test_basic();
    test_swap_long();
    test_saturate();
    test_sticky();
    test_equal();
    test_denormal();
    test_backpressure_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_align_shifter.md
# fp_align_shifter

Pre-normalization alignment unit for the floating-point add/subtract path. It accepts two IEEE-754 single-precision operands and orders them by magnitude. It then right-shifts the smaller operand's significand by the exponent difference, keeping guard, round and sticky bits. Its output feeds the significand adder, whose result the post-add normalizer left-shifts back; this block is that normalizer's counterpart on the input side. Shifting is iterative: a small FSM moves the operand a bounded number of bits per cycle, with valid/ready handshakes on both sides.

## Interface
- SHIFT_STEP, 4, maximum right-shift bits per SHIFT cycle; legal 1..27
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept; high only in IDLE
- a  input  32  operand A (sign, 8-bit exponent, 23-bit mantissa)
- b  input  32  operand B
- out_valid  output  1  aligned result valid
- out_ready  input  1  downstream accepts result
- sign_large  output  1  sign of larger-magnitude operand
- sign_small  output  1  sign of smaller operand
- exp_large  output  8  effective exponent of larger operand
- sig_large  output  24  hidden bit plus mantissa of larger operand
- sig_small  output  27  aligned smaller significand {24 bits, guard, round, sticky}
- swapped  output  1  1 when B is the larger operand
- special  output  1  NaN/Inf operand present (see Configuration)

## Operation
- Hidden bit is 1 when exponent != 0, else 0. Effective exponent is 1 when the field is 0 (denormal).
- Ordering: A is large if exp_a > exp_b, or if exp_a == exp_b and sig_a >= sig_b. Otherwise B is large and swapped=1.
- diff = eff_exp_large - eff_exp_small, unsigned 8 bits.
- The small significand is loaded as {sig, 3'b000}, 27 bits.
- Each right shift ORs every shifted-out bit into bit 0. Sticky never clears once set.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, capture both operands and compute ordering and diff.
    - diff==0 → DONE
    - diff>=27 → sig_small = {26'b0, |loaded}, then DONE
    - otherwise → SHIFT with rem=diff
  - SHIFT: shift by k=min(rem, SHIFT_STEP) and set rem -= k. When the new rem is 0, go to DONE.
  - DONE: out_valid=1, all outputs held stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. No operand is accepted in the cycle DONE is left.
- Reset asserted in any state returns the block to IDLE immediately and discards in-flight work.
- Reset values: out_valid=0, in_ready=1, every data output 0, swapped=0, special=0, rem=0.

## Timing
- Latency from the accept edge to out_valid high:
  - 1 cycle for diff==0 or diff>=27
  - otherwise 1+ceil(diff/SHIFT_STEP) cycles
- Throughput is one result per latency+1 cycles, or more if out_ready is held low.
- Outputs are registered with no combinational in→out path.
- in_ready is decoded from the state register only.

## Configuration
- FP_ALIGN_SPECIAL_EN defined:
  - An exponent field of 255 on either operand sets special=1 and goes straight to DONE without shifting.
  - The data outputs still carry the ordered operands, with sig_small unshifted.
- FP_ALIGN_SPECIAL_EN undefined:
  - special is tied to 0.
  - Exponent 255 is treated as an ordinary value.

## Structure
- Shared package fp_alu_pkg holds:
  - constants EXP_W=8, MAN_W=23, SIG_W=24, GRS_W=3, ALIGN_W=27, ALIGN_SAT=27
  - the FSM state enum {IDLE, SHIFT, DONE}
- Sub-module fp_sticky_shifter: combinational 27-bit right shift by 0..SHIFT_STEP with sticky OR-reduction. It is instantiated once, in the SHIFT datapath.

## Test plan
- Basic alignment: a=0x40400000, b=0x3F800000 → swapped=0, exp_large=128, sig_large=0xC00000, sig_small=0x2000000. out_valid 2 cycles after accept.
- Swap with long shift: a=0x3F800000, b=0x4B800000 → swapped=1, exp_large=151, sig_small=0x0000004. Latency 7 cycles at SHIFT_STEP=4.
- Saturated shift: a=0x4F800000, b=0x3F800001 (diff 32) → sig_small=0x0000001 (sticky only). Latency 1.
- Sticky accumulation: small significand 0x800001 with diff=5 → sig_small=0x200001.
- Equal exponents: a=0x3F800000, b=0x3FC00000 → swapped=1, sig_small=0x4000000, latency 1.
- Backpressure, then reset: hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0. Then assert rst_n=0 mid-SHIFT on a new op → next cycle out_valid=0, in_ready=1, and a following op completes correctly.
